// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: operation codes
// and controller state values.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers: one radix-2
// shift-add or restoring-divide step per cycle over a shared 2*WIDTH accumulator.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          state, state_next;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;

  logic               signed_op, op_is_div, accept;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] x,
                                                       input logic en);
    return en ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign accept    = (state == MD_IDLE) && start;

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_RUN;
      MD_RUN:  if (count == CNT_W'(WIDTH - 1)) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != MD_IDLE);
      done  <= (state == MD_FIX);
      if (accept)
        count <= '0;
      else if (state == MD_RUN)
        count <= count + 1'b1;
    end
  end

  // Multiply: upper half accumulates, multiplier bits shift out of the bottom.
  // Divide: upper half is the partial remainder, lower half shifts dividend
  // bits out of the top and quotient bits in at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (!is_div)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_shift >= {1'b0, opb})
      acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= op_is_div;
      sign_a <= signed_op && A[WIDTH-1];
      sign_b <= signed_op && B[WIDTH-1];
      if (op_is_div) begin
        acc <= {{WIDTH{1'b0}}, cond_neg(A, signed_op && A[WIDTH-1])};
        opb <= cond_neg(B, signed_op && B[WIDTH-1]);
      end else begin
        acc <= {{WIDTH{1'b0}}, cond_neg(B, signed_op && B[WIDTH-1])};
        opb <= cond_neg(A, signed_op && A[WIDTH-1]);
      end
    end else if (state == MD_RUN) begin
      acc <= acc_step;
    end
  end

  // A zero divisor leaves |A| in the remainder, so the remainder sign fix
  // restores A into HI; only the quotient needs overriding.
  assign prod_fixed = cond_neg_wide(acc, sign_a ^ sign_b);
  assign quot_fixed = (opb == '0) ? '1 : cond_neg(acc[WIDTH-1:0], sign_a ^ sign_b);
  assign rem_fixed  = cond_neg(acc[2*WIDTH-1:WIDTH], sign_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == MD_FIX) begin
      hi <= is_div ? rem_fixed  : prod_fixed[2*WIDTH-1:WIDTH];
      lo <= is_div ? quot_fixed : prod_fixed[WIDTH-1:0];
    end else if (state == MD_IDLE && !start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  assign result = {hi, lo};

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency, busy/done
// timing, MTHI/MTLO writes, ignored requests and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  // Drives a one-cycle start at the current negedge, scrambles the operands
  // afterwards, and returns the number of edges until done is seen (cap 60).
  task automatic issue_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 32'h5A5A5A5A; B = 32'hA5A5A5A5;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int lat;
    op = MD_MULT; A = 32'hFFFFFFFD; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 32'h0; B = 32'h0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_run: got %b expected 1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    checks++; if (lat != 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b expected 0", busy); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
    checks++; if (result !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_result: got %h expected ffffffffffffffeb", result); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mult_unsigned;
    int lat;
    issue_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    @(negedge clk);
    issue_op(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_neg_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h1) begin errors++; $display("FAIL mult_neg_lo: got %h expected 00000001", lo); end
    @(negedge clk);
  endtask

  task automatic test_div;
    int lat;
    issue_op(MD_DIV, 32'hFFFFFFF9, 32'd2, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", lat); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    @(negedge clk);
    issue_op(MD_DIVU, 32'd100, 32'd7, lat);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int lat;
    issue_op(MD_DIVU, 32'd100, 32'd0, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL divz_latency: got %0d expected 34", lat); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divuz_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h00000064) begin errors++; $display("FAIL divuz_hi: got %h expected 00000064", hi); end
    @(negedge clk);
    issue_op(MD_DIV, 32'hFFFFFFFB, 32'd0, lat);
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL divz_hi: got %h expected fffffffb", hi); end
    @(negedge clk);
  endtask

  task automatic test_div_overflow;
    int lat;
    issue_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    issue_op(MD_DIVU, 32'd100, 32'd7, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 34", lat); end
    issue_op(MD_MULTU, 32'd6, 32'd7, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
    checks++; if (result !== 64'd42) begin errors++; $display("FAIL b2b_result: got %h expected 000000000000002a", result); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo;
    wdata = 32'h1234; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h expected 00001234", hi); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b expected 0", done); end
    wdata = 32'h5678; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo: got %h expected 00005678", lo); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", hi); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b expected 0", done); end
    wdata = 32'hCAFE0001; hi_we = 1'b1; lo_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (result !== 64'hCAFE0001_CAFE0001) begin errors++; $display("FAIL mt_both: got %h expected cafe0001cafe0001", result); end
  endtask

  task automatic test_start_with_write;
    int lat;
    op = MD_MULTU; A = 32'd2; B = 32'd3; start = 1'b1;
    wdata = 32'hDEAD; hi_we = 1'b1; lo_we = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (hi !== 32'hCAFE0001) begin errors++; $display("FAIL startwr_hi_kept: got %h expected cafe0001", hi); end
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    checks++; if (result !== 64'd6) begin errors++; $display("FAIL startwr_result: got %h expected 0000000000000006", result); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int lat;
    op = MD_MULT; A = 32'd6; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (5) begin @(negedge clk); lat++; end
    op = MD_DIVU; A = 32'd1000; B = 32'd3; start = 1'b1;
    wdata = 32'h77777777; lo_we = 1'b1; hi_we = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    checks++; if (lat != 34) begin errors++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_lo: got %h expected 0000002a", lo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_second_start: busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int done_seen;
    op = MD_MULTU; A = 32'hFFFF; B = 32'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL rstmid_after: got %h expected 0", result); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(negedge clk);
    test_reset;
    test_mult;
    test_mult_unsigned;
    test_div;
    test_div_zero;
    test_div_overflow;
    test_back_to_back;
    test_mthi_mtlo;
    test_start_with_write;
    test_busy_ignore;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
